// File: rtl/fft_capture_ctrl.sv
// -----------------------------------------------------------------------------
// fft_capture_ctrl
//
// Purpose:
//   Captures one frame of 2^FRAME_LEN_LOG2 decimated samples from a stream
//   that cannot be stalled, and forwards them to the FFT input FIFO through
//   a registered valid/ready output stage. After a start pulse the block
//   waits STARTUP_CYCLES cycles for the front end to settle, then captures
//   the frame. With the optional trigger it first waits in ARM for a rising
//   crossing of trig_level.
//
// Optional feature:
//   FFT_CAPTURE_TRIGGER_EN  when defined, adds the trig_level input and the
//                           ARM state (rising-edge trigger on the decimated
//                           stream). When undefined, STARTUP goes straight
//                           to CAPTURE.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start, abort          single-cycle frame request / cancel
//   freq_div[7:0]         decimation: one sample every freq_div*256+1 cycles
//   s_tdata, s_tvalid     input sample stream (no backpressure)
//   trig_level            signed trigger threshold (trigger build only)
//   m_tdata, m_tvalid,
//   m_tready, m_tlast     output stream to the FFT FIFO
//   busy                  high in every state except IDLE
//   done                  one-cycle pulse when a frame completes
//   overflow              sticky: a sample was dropped while the output stalled
//   frame_cnt[15:0]       completed frames, wrapping
// -----------------------------------------------------------------------------
module fft_capture_ctrl #(
    parameter int DATA_WIDTH     = 16,
    parameter int FRAME_LEN_LOG2 = 10,
    parameter int STARTUP_CYCLES = 256
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         abort,
    input  logic [7:0]                   freq_div,
    input  logic [DATA_WIDTH-1:0]        s_tdata,
    input  logic                         s_tvalid,
`ifdef FFT_CAPTURE_TRIGGER_EN
    input  logic signed [DATA_WIDTH-1:0] trig_level,
`endif
    output logic [DATA_WIDTH-1:0]        m_tdata,
    output logic                         m_tvalid,
    input  logic                         m_tready,
    output logic                         m_tlast,
    output logic                         busy,
    output logic                         done,
    output logic                         overflow,
    output logic [15:0]                  frame_cnt
);

    // Index is one bit wider than the frame so "all samples loaded" is the
    // distinct value FRAME_N rather than a wrap back to 0.
    localparam int IW = FRAME_LEN_LOG2 + 1;
    localparam logic [IW-1:0] FRAME_N  = IW'(2 ** FRAME_LEN_LOG2);
    localparam logic [IW-1:0] IDX_LAST = IW'(2 ** FRAME_LEN_LOG2 - 1);
    localparam int SW = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;
    localparam logic [SW-1:0] SU_LAST = SW'(STARTUP_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_STARTUP = 3'd1,
`ifdef FFT_CAPTURE_TRIGGER_EN
        ST_ARM     = 3'd2,
`endif
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

`ifdef FFT_CAPTURE_TRIGGER_EN
    localparam state_t AFTER_STARTUP = ST_ARM;
`else
    localparam state_t AFTER_STARTUP = ST_CAPTURE;
`endif

    state_t                  state_reg, state_next;
    logic [SW-1:0]           su_cnt_reg;
    logic [15:0]             dec_cnt_reg;
    logic [IW-1:0]           idx_reg;
    logic [DATA_WIDTH-1:0]   m_tdata_reg;
    logic                    m_tvalid_reg;
    logic                    m_tlast_reg;
    logic                    overflow_reg;
    logic [15:0]             frame_cnt_reg;

    logic [15:0] dec_limit;
    logic        strobe;
    logic        dec_run;
    logic        handshake;
    logic        out_free;
    logic        cap_take;
    logic        trig_hit;
    logic        load;
    logic        drop;

    assign dec_limit = {freq_div, 8'h00};
    assign strobe    = (dec_cnt_reg == 16'd0);
    assign handshake = m_tvalid_reg && m_tready;
    // The output register can take a new sample if it is empty or is being
    // emptied on this same edge.
    assign out_free  = !m_tvalid_reg || m_tready;
    assign cap_take  = (state_reg == ST_CAPTURE) && s_tvalid && strobe && (idx_reg != FRAME_N);

`ifdef FFT_CAPTURE_TRIGGER_EN
    logic signed [DATA_WIDTH-1:0] prev_sample_reg;
    logic                         prev_valid_reg;

    assign dec_run  = (state_reg == ST_CAPTURE) || (state_reg == ST_ARM);
    // The crossing sample itself becomes index 0 of the frame.
    assign trig_hit = (state_reg == ST_ARM) && s_tvalid && strobe && prev_valid_reg
                      && (prev_sample_reg < trig_level)
                      && ($signed(s_tdata) >= trig_level);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_sample_reg <= '0;
            prev_valid_reg  <= 1'b0;
        end else if (state_reg == ST_ARM) begin
            if (s_tvalid && strobe) begin
                prev_sample_reg <= $signed(s_tdata);
                prev_valid_reg  <= 1'b1;
            end
        end else begin
            prev_valid_reg <= 1'b0;
        end
    end
`else
    assign dec_run  = (state_reg == ST_CAPTURE);
    assign trig_hit = 1'b0;
`endif

    assign load = (cap_take || trig_hit) && out_free && !abort;
    assign drop = cap_take && !out_free && !abort;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:    if (start) state_next = ST_STARTUP;
            ST_STARTUP: if (su_cnt_reg == SU_LAST) state_next = AFTER_STARTUP;
`ifdef FFT_CAPTURE_TRIGGER_EN
            ST_ARM:     if (trig_hit) state_next = ST_CAPTURE;
`endif
            ST_CAPTURE: if (handshake && m_tlast_reg) state_next = ST_DONE;
            ST_DONE:    state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
        if (abort) state_next = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            su_cnt_reg    <= '0;
            dec_cnt_reg   <= '0;
            idx_reg       <= '0;
            m_tdata_reg   <= '0;
            m_tvalid_reg  <= 1'b0;
            m_tlast_reg   <= 1'b0;
            overflow_reg  <= 1'b0;
            frame_cnt_reg <= '0;
        end else begin
            if (state_reg == ST_STARTUP && state_next == ST_STARTUP)
                su_cnt_reg <= su_cnt_reg + 1'b1;
            else
                su_cnt_reg <= '0;

            // The counter restarts on CAPTURE entry so the first capture
            // cycle always carries a strobe.
            if (state_next == ST_CAPTURE && state_reg != ST_CAPTURE)
                dec_cnt_reg <= '0;
            else if (dec_run)
                dec_cnt_reg <= (dec_cnt_reg == dec_limit) ? 16'd0 : dec_cnt_reg + 16'd1;
            else
                dec_cnt_reg <= '0;

            if (state_reg == ST_IDLE || abort)
                idx_reg <= '0;
            else if (load)
                idx_reg <= idx_reg + 1'b1;

            if (abort) begin
                m_tvalid_reg <= 1'b0;
                m_tlast_reg  <= 1'b0;
            end else if (load) begin
                m_tdata_reg  <= s_tdata;
                m_tvalid_reg <= 1'b1;
                m_tlast_reg  <= (idx_reg == IDX_LAST);
            end else if (handshake) begin
                m_tvalid_reg <= 1'b0;
                m_tlast_reg  <= 1'b0;
            end

            if (state_reg == ST_IDLE && start && !abort)
                overflow_reg <= 1'b0;
            else if (drop)
                overflow_reg <= 1'b1;

            if (state_reg == ST_DONE && !abort)
                frame_cnt_reg <= frame_cnt_reg + 16'd1;
        end
    end

    assign m_tdata   = m_tdata_reg;
    assign m_tvalid  = m_tvalid_reg;
    assign m_tlast   = m_tlast_reg;
    assign busy      = (state_reg != ST_IDLE);
    assign done      = (state_reg == ST_DONE);
    assign overflow  = overflow_reg;
    assign frame_cnt = frame_cnt_reg;

endmodule
